// File: rtl/pmp_csr_regs.sv
// Machine-mode PMP configuration/address register file (RV64) with lock, TOR-lock
// and WARL write rules. Registered one-cycle CSR response; live state feeds the PMP check.
module pmp_csr_regs #(
    parameter int unsigned NrPMPEntries = 8,
    parameter int unsigned PLEN         = 56,
    localparam int unsigned NE          = (NrPMPEntries > 0) ? NrPMPEntries : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     csr_req_i,
    input  logic                     csr_we_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [63:0]              csr_wdata_i,
    input  logic [1:0]               priv_lvl_i,
    output logic                     csr_rsp_valid_o,
    output logic [63:0]              csr_rdata_o,
    output logic                     csr_illegal_o,
    output logic [NE-1:0][7:0]       pmpcfg_o,
    output logic [NE-1:0][PLEN-3:0]  pmpaddr_o,
    output logic                     pmp_update_o
);

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] A_TOR  = 2'b01;

    logic [NE-1:0][7:0]      cfg_q, cfg_d;
    logic [NE-1:0][PLEN-3:0] addr_q, addr_d;
    logic [NE-1:0]           tor_lock;
    logic [63:0]             rd;
    logic [7:0]              wbyte;
    logic                    is_cfg0, is_cfg2, is_addr, legal, wr_en, changed;

    assign is_cfg0 = (csr_addr_i == 12'h3A0);
    assign is_cfg2 = (csr_addr_i == 12'h3A2);
    assign is_addr = (csr_addr_i[11:4] == 8'h3B);
    assign legal   = (priv_lvl_i == PRIV_M) && (is_cfg0 || is_cfg2 || is_addr);
    assign wr_en   = csr_req_i && legal && csr_we_i;

    // An address entry is frozen when the next entry is a locked TOR top bound.
    always_comb begin
        tor_lock = '0;
        for (int i = 0; i < int'(NE) - 1; i++)
            tor_lock[i] = cfg_q[i+1][7] && (cfg_q[i+1][4:3] == A_TOR);
    end

    // Read mux and next-state; every rule is evaluated against the pre-write state.
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        rd     = '0;
        wbyte  = '0;
        for (int i = 0; i < int'(NE); i++) begin
            if (i < int'(NrPMPEntries)) begin
                wbyte = csr_wdata_i[8*(i%8) +: 8];
                if ((i < 8) ? is_cfg0 : is_cfg2) begin
                    rd[8*(i%8) +: 8] = cfg_q[i];
                    if (wr_en && !cfg_q[i][7] && !(wbyte[1] && !wbyte[0]))
                        cfg_d[i] = wbyte & 8'h9F;
                end
                if (is_addr && csr_addr_i[3:0] == 4'(i)) begin
                    rd = {{(66-PLEN){1'b0}}, addr_q[i]};
                    if (wr_en && !cfg_q[i][7] && !tor_lock[i])
                        addr_d[i] = csr_wdata_i[PLEN-3:0];
                end
            end
        end
    end

    assign changed = (cfg_d != cfg_q) || (addr_d != addr_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_q           <= '0;
            addr_q          <= '0;
            csr_rsp_valid_o <= 1'b0;
            csr_rdata_o     <= '0;
            csr_illegal_o   <= 1'b0;
            pmp_update_o    <= 1'b0;
        end else begin
            cfg_q           <= cfg_d;
            addr_q          <= addr_d;
            csr_rsp_valid_o <= csr_req_i;
            csr_illegal_o   <= csr_req_i && !legal;
            csr_rdata_o     <= (csr_req_i && legal && !csr_we_i) ? rd : 64'd0;
            pmp_update_o    <= wr_en && changed;
        end
    end

    assign pmpcfg_o  = cfg_q;
    assign pmpaddr_o = addr_q;

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Bench for pmp_csr_regs: vector table plus hand sequences, expected responses
// queued at drive time and compared when the response strobe appears.
module tb_pmp_csr_regs;

    localparam int NR   = 8;
    localparam int PLEN = 56;
    localparam logic [1:0] PM = 2'b11;
    localparam logic [1:0] PS = 2'b01;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] AMAX = 64'h003F_FFFF_FFFF_FFFF;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    csr_req_i, csr_we_i;
    logic [11:0]             csr_addr_i;
    logic [63:0]             csr_wdata_i;
    logic [1:0]              priv_lvl_i;
    logic                    csr_rsp_valid_o, csr_illegal_o, pmp_update_o;
    logic [63:0]             csr_rdata_o;
    logic [NR-1:0][7:0]      pmpcfg_o;
    logic [NR-1:0][PLEN-3:0] pmpaddr_o;

    pmp_csr_regs #(.NrPMPEntries(NR), .PLEN(PLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .csr_req_i(csr_req_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .priv_lvl_i(priv_lvl_i),
        .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o), .pmpcfg_o(pmpcfg_o), .pmpaddr_o(pmpaddr_o),
        .pmp_update_o(pmp_update_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic we; logic [11:0] addr; logic [63:0] wdata; logic [1:0] priv;
        logic [63:0] rdata; logic ill; logic upd;
    } vec_t;
    typedef struct { logic [63:0] rdata; logic ill; logic upd; } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [11:0] a, logic [63:0] wd, logic [1:0] p,
                                logic [63:0] rd, logic ill, logic upd);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.priv = p;
        v.rdata = rd; v.ill = ill; v.upd = upd;
        return v;
    endfunction

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (csr_rsp_valid_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 64'(csr_rsp_valid_o), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rdata", csr_rdata_o, e.rdata);
                chk("illegal", 64'(csr_illegal_o), 64'(e.ill));
                chk("update", 64'(pmp_update_o), 64'(e.upd));
            end
        end else if (pmp_update_o) begin
            chk("update_without_rsp", 64'(pmp_update_o), 64'd0);
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        @(posedge clk_i); #1;
        csr_req_i = 1'b1; csr_we_i = v.we; csr_addr_i = v.addr;
        csr_wdata_i = v.wdata; priv_lvl_i = v.priv;
        e.rdata = v.rdata; e.ill = v.ill; e.upd = v.upd;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        csr_req_i = 1'b0; csr_we_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk_i);
        chk({tag, "_rsp_valid"}, 64'(csr_rsp_valid_o), 64'd0);
        chk({tag, "_rdata"}, csr_rdata_o, 64'd0);
        chk({tag, "_illegal"}, 64'(csr_illegal_o), 64'd0);
        chk({tag, "_update"}, 64'(pmp_update_o), 64'd0);
        chk({tag, "_pmpcfg"}, pmpcfg_o, 64'd0);
        chk({tag, "_pmpaddr0"}, 64'(pmpaddr_o[0]), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0; csr_req_i = 1'b0; csr_we_i = 1'b0;
        csr_addr_i = '0; csr_wdata_i = '0; priv_lvl_i = PM;
        repeat (2) @(posedge clk_i);
        check_reset_state("reset");

        vecs.push_back(mk(0, 12'h3A0, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3B3, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3A0, 64'h8F0F,        PM, 0,          0, 1));
        vecs.push_back(mk(0, 12'h3A0, 0,               PM, 64'h8F0F,   0, 0));
        vecs.push_back(mk(1, 12'h3A0, 0,               PM, 0,          0, 1));
        vecs.push_back(mk(0, 12'h3A0, 0,               PM, 64'h8F00,   0, 0));
        vecs.push_back(mk(1, 12'h3B0, 64'h1234,        PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3B0, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3A0, 64'h0002_8F00,   PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3A0, 64'h0003_8F00,   PM, 0,          0, 1));
        vecs.push_back(mk(0, 12'h3A0, 0,               PM, 64'h3_8F00, 0, 0));
        vecs.push_back(mk(1, 12'h3A0, 64'h0063_8F00,   PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3A0, 0,               PS, 0,          1, 0));
        vecs.push_back(mk(1, 12'h3A1, ALL1,            PM, 0,          1, 0));
        vecs.push_back(mk(0, 12'h3A3, 0,               PM, 0,          1, 0));
        vecs.push_back(mk(0, 12'h300, 0,               PM, 0,          1, 0));
        vecs.push_back(mk(1, 12'h3A2, ALL1,            PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3A2, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3BF, ALL1,            PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3BF, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3B7, ALL1,            PM, 0,          0, 1));
        vecs.push_back(mk(0, 12'h3B7, 0,               PM, AMAX,       0, 0));
        vecs.push_back(mk(1, 12'h3B7, ALL1,            PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3B3, 64'hABCD,        PS, 0,          1, 0));
        vecs.push_back(mk(0, 12'h3B3, 0,               PM, 0,          0, 0));
        vecs.push_back(mk(1, 12'h3B1, 64'h55,          PM, 0,          0, 0));
        vecs.push_back(mk(0, 12'h3B1, 0,               PM, 0,          0, 0));

        @(posedge clk_i); #1; rst_ni = 1'b1;
        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);
        idle();
        @(negedge clk_i);
        chk("cfg0_live", 64'(pmpcfg_o[0]), 64'h00);
        chk("cfg1_live", 64'(pmpcfg_o[1]), 64'h8F);
        chk("cfg2_live", 64'(pmpcfg_o[2]), 64'h03);
        chk("addr7_live", 64'(pmpaddr_o[7]), AMAX);

        // Request colliding with reset gets no response; locks clear.
        @(posedge clk_i); #1;
        rst_ni = 1'b0; csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 12'h3A0; priv_lvl_i = PM;
        @(posedge clk_i); #1; csr_req_i = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_rsp", 64'(csr_rsp_valid_o), 64'd0);
        check_reset_state("reset2");

        // Entry1 locked NAPOT does not freeze pmpaddr0.
        @(posedge clk_i); #1; rst_ni = 1'b1;
        issue(mk(1, 12'h3A0, 64'h9B00, PM, 0,        0, 1));
        issue(mk(1, 12'h3B0, 64'h1234, PM, 0,        0, 1));
        issue(mk(0, 12'h3B0, 0,        PM, 64'h1234, 0, 0));
        issue(mk(1, 12'h3B1, 64'h77,   PM, 0,        0, 0));
        idle();
        @(negedge clk_i);
        chk("cfg1_napot", 64'(pmpcfg_o[1]), 64'h9B);
        chk("addr0_live", 64'(pmpaddr_o[0]), 64'h1234);

        repeat (3) idle();
        @(negedge clk_i);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
